pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Drives the en/clear pair of each inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves load-use hazards, branch redirects, data-memory wait and multi-cycle EX ops (MAC/divide unit used by TFLM kernels).
- The multi-cycle unit is driven through a start/done handshake FSM.
- Pipeline register semantics: clear acts only when en=1, so a bubble is en=1, clear=1 and a freeze is en=0.

Parameters:
REG_AW, 5, register-index width
CNT_W, 32, perf counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
id_rs1  in  REG_AW  ID source index 1
id_rs2  in  REG_AW  ID source index 2
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  EX destination index
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump
ex_mc_op  in  1  EX holds a multi-cycle op
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
mem_stall  in  1  data memory not ready
pc_en  out  1  PC update enable
if_id_en, if_id_clear  out  1,1  IF/ID control
id_ex_en, id_ex_clear  out  1,1  ID/EX control
ex_mem_en, ex_mem_clear  out  1,1  EX/MEM control
mem_wb_en, mem_wb_clear  out  1,1  MEM/WB control
mc_start  out  1  launch pulse to multi-cycle unit
mc_busy  out  1  FSM not in MC_IDLE

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to MC_IDLE.
- While rst=1: all en, all clear, pc_en and mc_start are 0.
- Stage controls are combinational from inputs and FSM state.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- mc_stall = ex_mc_op & (state!=MC_DONE).
- Priority, highest first:
  1. mem_stall: every en=0, pc_en=0.
  2. mc_stall: pc_en=0, if_id_en=0, id_ex_en=0; ex_mem en=1 clear=1 (bubble); mem_wb en=1 clear=0.
  3. ex_branch_taken: pc_en=1; if_id and id_ex en=1 clear=1; others normal. Overrides load_use because the ID instruction is squashed.
  4. load_use: pc_en=0, if_id_en=0; id_ex en=1 clear=1; others normal. Gives exactly 1 bubble.
  5. Normal: every en=1, clear=0, pc_en=1.
- MC FSM states and transitions:
  - MC_IDLE: go to MC_START when ex_mc_op=1 and mem_stall=0.
  - MC_START: mc_start=1 for this cycle only. Go to MC_DONE if mc_done=1, else MC_WAIT.
  - MC_WAIT: go to MC_DONE on mc_done=1.
  - MC_DONE: release cycle, EX advances. Go to MC_IDLE when mem_stall=0; hold MC_DONE while mem_stall=1.
- MC FSM boundary rules:
  - mc_done outside MC_START/MC_WAIT is ignored.
  - mem_stall during MC_WAIT does not block the transition to MC_DONE.
  - In MC_DONE the op never re-launches.
  - Back-to-back mc ops: MC_DONE → MC_IDLE → MC_START. One idle-stall cycle between ops is acceptable.
  - Minimum stall for an mc op is 2 cycles (MC_IDLE and MC_START with an immediate done).
- Reset mid-MC_WAIT: next state is MC_IDLE and no mc_start is issued during reset. The unit is reset by the same rst.

Optional Feature:
Macro PIPE_CTRL_PERF_EN. When defined, adds outputs:
- stall_cycles [CNT_W-1:0]: increments in each cycle where pc_en=0 and rst=0.
- flush_count [CNT_W-1:0]: increments on each cycle where a branch flush is taken.
Both counters reset to 0 and wrap modulo 2^CNT_W. When undefined, these ports and registers do not exist.

Decomposition:
- Package pipe_ctrl_pkg: mc_state_t enum (MC_IDLE, MC_START, MC_WAIT, MC_DONE) and the REG_AW default constant.
- Sub-module pipe_mc_fsm: the handshake FSM. Inputs ex_mc_op, mc_done, mem_stall; outputs state, mc_start, mc_busy.
- Priority logic stays in the top.

Test Plan:
1. Load-use: EX load with ex_rd=5, ID id_rs1=5 used -> one cycle of pc_en=0, if_id_en=0, id_ex_clear=1; the next cycle is normal. Repeat with ex_rd=0 -> no stall.
2. Branch: ex_branch_taken=1 -> if_id_clear=1 and id_ex_clear=1 with en=1, pc_en=1, for 1 cycle only.
3. Branch + load-use in the same cycle -> branch flush response; pc_en=1, no freeze.
4. MC op with mc_done 3 cycles after mc_start:
   - mc_start is high in exactly one cycle.
   - Stall lasts through MC_DONE-1.
   - ex_mem_clear=1 each stall cycle.
   - EX advances in the MC_DONE cycle.
   - mc_busy falls afterward.
5. mem_stall=1 for 2 cycles during MC_WAIT, with mc_done arriving inside that window -> all en=0 throughout; FSM holds MC_DONE until mem_stall=0; no second mc_start.
6. rst=1 asserted during MC_WAIT -> outputs all 0 while rst is held; FSM returns to MC_IDLE. With PIPE_CTRL_PERF_EN defined, counters read 0 after reset and stall_cycles counts case 1 as 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_START = 2'd1,
        MC_WAIT  = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_t;

    // Full set of stage controls, ordered from the PC down to MEM/WB.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_clear;
        logic id_ex_en;
        logic id_ex_clear;
        logic ex_mem_en;
        logic ex_mem_clear;
        logic mem_wb_en;
        logic mem_wb_clear;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_OFF      = 9'b0_00_00_00_00;
    localparam pipe_ctl_t CTL_NORMAL   = 9'b1_10_10_10_10;
    localparam pipe_ctl_t CTL_MEM_HOLD = 9'b0_00_00_00_00;
    localparam pipe_ctl_t CTL_MC_STALL = 9'b0_00_00_11_10;
    localparam pipe_ctl_t CTL_BRANCH   = 9'b1_11_11_10_10;
    localparam pipe_ctl_t CTL_LOAD_USE = 9'b0_00_11_10_10;

endpackage

// File: rtl/pipe_mc_fsm.sv
// Start/done handshake sequencer for the multi-cycle EX unit (MAC/divide).
module pipe_mc_fsm
    import pipe_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      ex_mc_op,
    input  logic      mc_done,
    input  logic      mem_stall,
    output mc_state_t state,
    output logic      mc_start,
    output logic      mc_busy
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MC_IDLE;
            mc_start <= 1'b0;
            mc_busy  <= 1'b0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (ex_mc_op && !mem_stall) begin
                        state    <= MC_START;
                        mc_start <= 1'b1;
                        mc_busy  <= 1'b1;
                    end
                end
                MC_START: begin
                    mc_start <= 1'b0;
                    state    <= mc_done ? MC_DONE : MC_WAIT;
                end
                // A data-memory stall does not hold off completion here.
                MC_WAIT: begin
                    if (mc_done) state <= MC_DONE;
                end
                MC_DONE: begin
                    if (!mem_stall) begin
                        state   <= MC_IDLE;
                        mc_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= MC_IDLE;
                    mc_start <= 1'b0;
                    mc_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: drives en/clear of each pipeline
// register and the PC enable. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ex_mc_op,
    input  logic              mc_done,
    input  logic              mem_stall,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_clear,
    output logic              id_ex_en,
    output logic              id_ex_clear,
    output logic              ex_mem_en,
    output logic              ex_mem_clear,
    output logic              mem_wb_en,
    output logic              mem_wb_clear,
    output logic              mc_start,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
`endif
    output logic              mc_busy
);

    mc_state_t mc_state;
    logic      mc_start_q;
    logic      load_use;
    logic      mc_stall;
    logic      flush_taken;
    pipe_ctl_t ctl;

    pipe_mc_fsm u_mc_fsm (
        .clk       (clk),
        .rst       (rst),
        .ex_mc_op  (ex_mc_op),
        .mc_done   (mc_done),
        .mem_stall (mem_stall),
        .state     (mc_state),
        .mc_start  (mc_start_q),
        .mc_busy   (mc_busy)
    );

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));
    assign mc_stall = ex_mc_op && (mc_state != MC_DONE);

    // NOTE: ctl and flush_taken get a default before any branch, so no path
    // leaves them unassigned and no latch is inferred.
    always_comb begin
        ctl         = CTL_OFF;
        flush_taken = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                ctl = CTL_MEM_HOLD;
            end else if (mc_stall) begin
                ctl = CTL_MC_STALL;
            end else if (ex_branch_taken) begin
                // The ID instruction is squashed, so a load-use on it is moot.
                ctl         = CTL_BRANCH;
                flush_taken = 1'b1;
            end else if (load_use) begin
                ctl = CTL_LOAD_USE;
            end else begin
                ctl = CTL_NORMAL;
            end
        end
    end

    assign {pc_en, if_id_en, if_id_clear, id_ex_en, id_ex_clear,
            ex_mem_en, ex_mem_clear, mem_wb_en, mem_wb_clear} = ctl;
    assign mc_start = mc_start_q && !rst;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en)      stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_taken) flush_count  <= flush_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (PIPE_CTRL_PERF_EN optional).
module tb_pipeline_hazard_ctrl;

    // Expected stage-control vectors: {pc_en, if_id en/clr, id_ex en/clr, ex_mem en/clr, mem_wb en/clr}
    localparam logic [8:0] E_OFF    = 9'b0_00_00_00_00;
    localparam logic [8:0] E_NORMAL = 9'b1_10_10_10_10;
    localparam logic [8:0] E_MEMST  = 9'b0_00_00_00_00;
    localparam logic [8:0] E_MC     = 9'b0_00_00_11_10;
    localparam logic [8:0] E_BRANCH = 9'b1_11_11_10_10;
    localparam logic [8:0] E_LU     = 9'b0_00_11_10_10;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
    logic       ex_mc_op, mc_done, mem_stall;
    logic       pc_en, if_id_en, if_id_clear, id_ex_en, id_ex_clear;
    logic       ex_mem_en, ex_mem_clear, mem_wb_en, mem_wb_clear;
    logic       mc_start, mc_busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif
    logic [8:0] ctl_obs;

    int n_compared   = 0;
    int n_mismatched = 0;
    int start_seen   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_op        (ex_mc_op),
        .mc_done         (mc_done),
        .mem_stall       (mem_stall),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_clear     (if_id_clear),
        .id_ex_en        (id_ex_en),
        .id_ex_clear     (id_ex_clear),
        .ex_mem_en       (ex_mem_en),
        .ex_mem_clear    (ex_mem_clear),
        .mem_wb_en       (mem_wb_en),
        .mem_wb_clear    (mem_wb_clear),
        .mc_start        (mc_start),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
`endif
        .mc_busy         (mc_busy)
    );

    assign ctl_obs = {pc_en, if_id_en, if_id_clear, id_ex_en, id_ex_clear,
                      ex_mem_en, ex_mem_clear, mem_wb_en, mem_wb_clear};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_mc_op = 1'b0; mc_done = 1'b0; mem_stall = 1'b0;
    endtask

    // One clock cycle: inputs already applied, sample at negedge, then step past posedge.
    task automatic cycle(input string tag, input logic [8:0] e_ctl,
                         input logic e_start, input logic e_busy);
        @(negedge clk);
        check({tag, ".ctl"},   32'(ctl_obs),  32'(e_ctl));
        check({tag, ".start"}, 32'(mc_start), 32'(e_start));
        check({tag, ".busy"},  32'(mc_busy),  32'(e_busy));
        if (mc_start) start_seen++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        ex_mc_op = 1'b1;                       // must not launch while in reset
        cycle("rst0", E_OFF, 1'b0, 1'b0);
        cycle("rst1", E_OFF, 1'b0, 1'b0);
        rst = 1'b0;
        set_idle();
        cycle("idle", E_NORMAL, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        check("perf.stall_rst", stall_cycles, 32'd0);
        check("perf.flush_rst", flush_count, 32'd0);
`endif

        // Load-use on rs1, then the bubbled cycle is normal
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        cycle("lu_rs1", E_LU, 1'b0, 1'b0);
        set_idle();
        cycle("lu_after", E_NORMAL, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        check("perf.stall_lu", stall_cycles, 32'd1);
`endif
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        cycle("lu_rs2", E_LU, 1'b0, 1'b0);
        set_idle();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        cycle("lu_x0", E_NORMAL, 1'b0, 1'b0);
        set_idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b0;
        cycle("lu_unused", E_NORMAL, 1'b0, 1'b0);
        set_idle();

        // Branch flush for one cycle, then branch overriding load-use
        ex_branch_taken = 1'b1;
        cycle("br", E_BRANCH, 1'b0, 1'b0);
        set_idle();
        cycle("br_after", E_NORMAL, 1'b0, 1'b0);
        ex_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
        cycle("br_lu", E_BRANCH, 1'b0, 1'b0);
        set_idle();
`ifdef PIPE_CTRL_PERF_EN
        check("perf.flush", flush_count, 32'd2);
`endif

        // MC op, mc_done three cycles after mc_start
        start_seen = 0;
        ex_mc_op = 1'b1;
        cycle("mc_idle", E_MC, 1'b0, 1'b0);
        cycle("mc_start", E_MC, 1'b1, 1'b1);
        cycle("mc_wait1", E_MC, 1'b0, 1'b1);
        cycle("mc_wait2", E_MC, 1'b0, 1'b1);
        mc_done = 1'b1;
        cycle("mc_wait3", E_MC, 1'b0, 1'b1);
        mc_done = 1'b0;
        cycle("mc_done", E_NORMAL, 1'b0, 1'b1);
        ex_mc_op = 1'b0;
        cycle("mc_after", E_NORMAL, 1'b0, 1'b0);
        check("mc.start_count", 32'(start_seen), 32'd1);

        // mem_stall across MC_WAIT with mc_done inside, held into MC_DONE
        start_seen = 0;
        ex_mc_op = 1'b1;
        cycle("ms_idle", E_MC, 1'b0, 1'b0);
        cycle("ms_start", E_MC, 1'b1, 1'b1);
        mem_stall = 1'b1;
        cycle("ms_wait", E_MEMST, 1'b0, 1'b1);
        mc_done = 1'b1;
        cycle("ms_wait_done", E_MEMST, 1'b0, 1'b1);
        mc_done = 1'b0;
        cycle("ms_done_hold", E_MEMST, 1'b0, 1'b1);
        mem_stall = 1'b0;
        cycle("ms_done", E_NORMAL, 1'b0, 1'b1);
        ex_mc_op = 1'b0;
        cycle("ms_after", E_NORMAL, 1'b0, 1'b0);
        check("ms.start_count", 32'(start_seen), 32'd1);

        // Reset asserted mid-MC_WAIT
        ex_mc_op = 1'b1;
        cycle("rw_idle", E_MC, 1'b0, 1'b0);
        cycle("rw_start", E_MC, 1'b1, 1'b1);
        rst = 1'b1;
        cycle("rw_rst_wait", E_OFF, 1'b0, 1'b1);
`ifdef PIPE_CTRL_PERF_EN
        check("perf.stall_clr", stall_cycles, 32'd0);
        check("perf.flush_clr", flush_count, 32'd0);
`endif
        cycle("rw_rst_idle", E_OFF, 1'b0, 1'b0);
        rst = 1'b0;
        ex_mc_op = 1'b0;
        cycle("rw_after", E_NORMAL, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
